// File: rtl/quad_velocity_meter.sv
// Velocity estimator: samples a wrapping position count every SAMPLE_DIV cycles,
// forms signed deltas and outputs their moving average (counts per sample period).
module quad_velocity_meter #(
  parameter int CNT_W      = 16,
  parameter int SAMPLE_DIV = 50000,
  parameter int AVG_LOG2   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] vel,
  output logic             vel_valid,
  output logic             sample_tk
);
  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int TMR_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int PTR_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SUM_W  = CNT_W + AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;

  logic [TMR_W-1:0]        timer_reg;
  logic [CNT_W-1:0]        prev_reg;
  logic                    primed_reg;
  logic signed [CNT_W-1:0] delta_reg;
  logic                    d1_valid_reg;
  logic                    d2_valid_reg;
  logic [PTR_W-1:0]        wr_ptr_reg;
  logic [FILL_W-1:0]       fill_reg;
  logic signed [SUM_W-1:0] sum_reg;
  logic signed [CNT_W-1:0] ring_reg [DEPTH];
  logic signed [CNT_W-1:0] old_val;

  assign sample_tk = en && (timer_reg == TMR_W'(SAMPLE_DIV - 1));
  assign old_val   = ring_reg[wr_ptr_reg];

  // Sample timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      timer_reg <= '0;
    else if (!en || sample_tk)
      timer_reg <= '0;
    else
      timer_reg <= timer_reg + TMR_W'(1);
  end

  // Stage 1: the first tick after enable only primes prev; later ticks yield a delta.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg     <= '0;
      primed_reg   <= 1'b0;
      delta_reg    <= '0;
      d1_valid_reg <= 1'b0;
    end else if (!en) begin
      primed_reg   <= 1'b0;
      d1_valid_reg <= 1'b0;
    end else begin
      d1_valid_reg <= 1'b0;
      if (sample_tk) begin
        prev_reg <= count;
        if (primed_reg) begin
          delta_reg    <= count - prev_reg;
          d1_valid_reg <= 1'b1;
        end else begin
          primed_reg <= 1'b1;
        end
      end
    end
  end

  // Stage 2: ring buffer and running sum of the last DEPTH deltas
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ring_reg[i] <= '0;
      wr_ptr_reg   <= '0;
      fill_reg     <= '0;
      sum_reg      <= '0;
      d2_valid_reg <= 1'b0;
    end else if (!en) begin
      for (int i = 0; i < DEPTH; i++) ring_reg[i] <= '0;
      wr_ptr_reg   <= '0;
      fill_reg     <= '0;
      sum_reg      <= '0;
      d2_valid_reg <= 1'b0;
    end else begin
      d2_valid_reg <= d1_valid_reg;
      if (d1_valid_reg) begin
        ring_reg[wr_ptr_reg] <= delta_reg;
        sum_reg <= sum_reg + SUM_W'(delta_reg) - SUM_W'(old_val);
        if (wr_ptr_reg == PTR_W'(DEPTH - 1))
          wr_ptr_reg <= '0;
        else
          wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (fill_reg != FILL_W'(DEPTH))
          fill_reg <= fill_reg + FILL_W'(1);
      end
    end
  end

  // Stage 3: publish the floored average once the window is full; vel holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vel       <= '0;
      vel_valid <= 1'b0;
    end else if (!en) begin
      vel_valid <= 1'b0;
    end else begin
      vel_valid <= 1'b0;
      if (d2_valid_reg && fill_reg == FILL_W'(DEPTH)) begin
        vel       <= CNT_W'(sum_reg >>> AVG_LOG2);
        vel_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_quad_velocity_meter.sv
// Directed bench for quad_velocity_meter (SAMPLE_DIV=10, AVG_LOG2=2): table of
// per-tick vectors plus hand sequences for en drop and mid-pipeline reset.
module tb_quad_velocity_meter;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] count;
  logic [15:0] vel;
  logic        vel_valid;
  logic        sample_tk;

  int total = 0;
  int bad   = 0;

  quad_velocity_meter #(.CNT_W(16), .SAMPLE_DIV(10), .AVG_LOG2(2)) dut (
    .clk(clk), .rst(rst), .en(en), .count(count),
    .vel(vel), .vel_valid(vel_valid), .sample_tk(sample_tk)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          dis;   // cycles of en=0 before this vector (0 = none)
    logic [15:0] cnt;
    logic        ev;
    logic [15:0] evel;
  } vec_t;

  vec_t tbl[40];
  int   n = 0;

  task automatic add(input int dis, input logic [15:0] c, input logic ev, input logic [15:0] evl);
    tbl[n].dis  = dis;
    tbl[n].cnt  = c;
    tbl[n].ev   = ev;
    tbl[n].evel = evl;
    n++;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (sample_tk) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL tick_timeout: got no sample_tk want sample_tk within 30 cycles");
    end
  endtask

  // Disable for dis cycles (vel must hold evel, no vel_valid), then present one
  // count at the next tick and check outputs 3 edges after the sample instant.
  task automatic apply(input int idx, input int dis, input logic [15:0] c,
                       input logic ev, input logic [15:0] evl);
    bit ok;
    int vv;
    int vm;
    if (dis > 0) begin
      vv = 0;
      vm = 0;
      en = 1'b0;
      repeat (dis) begin
        @(posedge clk);
        #1;
        if (vel_valid) vv++;
        if (vel !== evl) vm++;
      end
      chk("dis_valid_cycles", 16'(vv), 16'd0);
      chk("dis_vel_changed", 16'(vm), 16'd0);
      en = 1'b1;
    end
    count = c;
    wait_tick(ok);
    if (ok) begin
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", idx), 16'(vel_valid), 16'(ev));
      chk($sformatf("vec%0d_vel", idx), vel, evl);
      $display("vec %0d count=%h vel_valid=%0b vel=%h", idx, c, vel_valid, vel);
    end
  endtask

  initial begin
    bit ok;
    int vv;
    int vm;

    // constant +3 from 0x0000 (first 4 ticks are warm-up)
    add(0, 16'h0000, 1'b0, 16'h0000);
    add(0, 16'h0003, 1'b0, 16'h0000);
    add(0, 16'h0006, 1'b0, 16'h0000);
    add(0, 16'h0009, 1'b0, 16'h0000);
    add(0, 16'h000C, 1'b1, 16'h0003);
    add(0, 16'h000F, 1'b1, 16'h0003);
    add(0, 16'h0012, 1'b1, 16'h0003);
    // reverse -3 across wrap
    add(3, 16'h0002, 1'b0, 16'h0003);
    add(0, 16'hFFFF, 1'b0, 16'h0003);
    add(0, 16'hFFFC, 1'b0, 16'h0003);
    add(0, 16'hFFF9, 1'b0, 16'h0003);
    add(0, 16'hFFF6, 1'b1, 16'hFFFD);
    // floor rounding: +1,+2,+2,+2 then -1,-2,-2,-2
    add(3, 16'h0100, 1'b0, 16'hFFFD);
    add(0, 16'h0101, 1'b0, 16'hFFFD);
    add(0, 16'h0103, 1'b0, 16'hFFFD);
    add(0, 16'h0105, 1'b0, 16'hFFFD);
    add(0, 16'h0107, 1'b1, 16'h0001);
    add(0, 16'h0106, 1'b1, 16'h0001);
    add(0, 16'h0104, 1'b1, 16'h0000);
    add(0, 16'h0102, 1'b1, 16'hFFFF);
    add(0, 16'h0100, 1'b1, 16'hFFFE);
    // +5 across wrap
    add(3, 16'hFFFE, 1'b0, 16'hFFFE);
    add(0, 16'h0003, 1'b0, 16'hFFFE);
    add(0, 16'h0008, 1'b0, 16'hFFFE);
    add(0, 16'h000D, 1'b0, 16'hFFFE);
    add(0, 16'h0012, 1'b1, 16'h0005);
    // -5 across wrap
    add(3, 16'h0002, 1'b0, 16'h0005);
    add(0, 16'hFFFD, 1'b0, 16'h0005);
    add(0, 16'hFFF8, 1'b0, 16'h0005);
    add(0, 16'hFFF3, 1'b0, 16'h0005);
    add(0, 16'hFFEE, 1'b1, 16'hFFFB);
    // speed 3 again, ahead of the en-drop sequence
    add(3, 16'h0500, 1'b0, 16'hFFFB);
    add(0, 16'h0503, 1'b0, 16'hFFFB);
    add(0, 16'h0506, 1'b0, 16'hFFFB);
    add(0, 16'h0509, 1'b0, 16'hFFFB);
    add(0, 16'h050C, 1'b1, 16'h0003);

    rst   = 1'b1;
    en    = 1'b0;
    count = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_vel", vel, 16'h0000);
    chk("reset_vel_valid", 16'(vel_valid), 16'd0);
    chk("reset_sample_tk", 16'(sample_tk), 16'd0);
    rst = 1'b0;
    @(negedge clk);
    en = 1'b1;

    for (int i = 0; i < n; i++)
      apply(i, tbl[i].dis, tbl[i].cnt, tbl[i].ev, tbl[i].evel);

    // en dropped one edge after a sample instant: in-flight delta discarded, vel holds 3
    count = 16'h050F;
    wait_tick(ok);
    @(posedge clk);
    #1;
    en = 1'b0;
    vv = 0;
    vm = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (vel_valid) vv++;
      if (vel !== 16'h0003) vm++;
    end
    chk("endrop_valid_cycles", 16'(vv), 16'd0);
    chk("endrop_vel_changed", 16'(vm), 16'd0);
    $display("en drop: 25 cycles disabled, vel=%h", vel);
    en = 1'b1;
    apply(100, 0, 16'h1000, 1'b0, 16'h0003);
    apply(101, 0, 16'h1005, 1'b0, 16'h0003);
    apply(102, 0, 16'h100A, 1'b0, 16'h0003);
    apply(103, 0, 16'h100F, 1'b0, 16'h0003);
    apply(104, 0, 16'h1014, 1'b1, 16'h0005);

    // async reset between sample instant and vel_valid
    apply(200, 3, 16'h2000, 1'b0, 16'h0005);
    apply(201, 0, 16'h2002, 1'b0, 16'h0005);
    apply(202, 0, 16'h2004, 1'b0, 16'h0005);
    apply(203, 0, 16'h2006, 1'b0, 16'h0005);
    apply(204, 0, 16'h2008, 1'b1, 16'h0002);
    count = 16'h200A;
    wait_tick(ok);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_vel", vel, 16'h0000);
    chk("rst_async_valid", 16'(vel_valid), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    vv = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (vel_valid) vv++;
    end
    chk("rst_inflight_valid", 16'(vv), 16'd0);
    $display("mid-pipeline reset: vel=%h", vel);
    apply(300, 0, 16'h200C, 1'b0, 16'h0000);
    apply(301, 0, 16'h200E, 1'b0, 16'h0000);
    apply(302, 0, 16'h2010, 1'b0, 16'h0000);
    apply(303, 0, 16'h2012, 1'b0, 16'h0000);
    apply(304, 0, 16'h2014, 1'b1, 16'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
